// File: rtl/score_pulse_gen.sv
// score_pulse_gen: buffers landing points and drains them as single-cycle
// 'increase' pulses, spaced so the downstream one-point-per-pulse display
// counter never misses a point. Repeat landings on the same platform are ignored.
module score_pulse_gen #(
    parameter int ID_WIDTH   = 4,
    parameter int PEND_WIDTH = 4,
    parameter int GAP        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  module_en,
    input  logic                  land_valid,
    input  logic [ID_WIDTH-1:0]   land_id,
    input  logic [2:0]            land_pts,
    output logic                  land_ready,
    output logic                  increase,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  busy
);

    // gap_cnt only ever holds values 0..GAP-1
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    // Highest pending value that can still absorb a worst-case 7-point landing
    localparam logic [PEND_WIDTH-1:0] READY_LIMIT = PEND_WIDTH'((2 ** PEND_WIDTH) - 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP_S = 2'd2
    } state_t;

    state_t              state;
    logic [GAP_W-1:0]    gap_cnt;
    logic                last_valid;
    logic [ID_WIDTH-1:0] last_id;

    logic accept;
    logic is_dup;
    logic add_pts;
    logic start_pulse;

    // Accept and decrement may land on the same edge; both must apply.
    function automatic logic [PEND_WIDTH-1:0] next_pending(
        input logic [PEND_WIDTH-1:0] cur,
        input logic                  add,
        input logic [2:0]            pts,
        input logic                  dec
    );
        logic [PEND_WIDTH-1:0] sum;
        sum = cur;
        if (add) sum = sum + PEND_WIDTH'(pts);
        if (dec) sum = sum - PEND_WIDTH'(1);
        return sum;
    endfunction

    // Ready is held low during reset as well, since nothing can be accepted then.
    assign land_ready  = rst && module_en && (pending <= READY_LIMIT);
    assign accept      = land_valid && land_ready;
    assign is_dup      = last_valid && (land_id == last_id);
    assign add_pts     = accept && !is_dup;
    assign start_pulse = (state == IDLE) && (pending != '0);
    assign busy        = (pending != '0) || (state != IDLE);

    // Pending-points bookkeeping, duplicate filter and pulse-spacing FSM
    always_ff @(posedge clk) begin
        if (!rst || !module_en) begin
            state      <= IDLE;
            pending    <= '0;
            gap_cnt    <= '0;
            increase   <= 1'b0;
            last_valid <= 1'b0;
            last_id    <= '0;
        end else begin
            pending <= next_pending(pending, add_pts, land_pts, start_pulse);

            if (add_pts) begin
                last_id    <= land_id;
                last_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        state    <= PULSE;
                        increase <= 1'b1;
                    end
                end
                PULSE: begin
                    state    <= GAP_S;
                    gap_cnt  <= GAP_W'(GAP - 1);
                    increase <= 1'b0;
                end
                GAP_S: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    increase <= 1'b0;
                end
            endcase
        end
    end

endmodule
